capture_pkt_buffer: RTL and testbench

Store-and-forward packet buffer directly downstream of the integration capture stage. It accepts the 64-bit integration packets, one word per beat with tlast on the final word, into a single-clock circular RAM. It releases a packet to the readout/DMA side only once its last word has been stored, and drops whole packets that cannot fit rather than back-pressuring the capture stage. It also keeps packet and drop statistics for slow-control readback.

---
 rtl/capture_pkt_buffer.sv | 152 +++++++++++++++
 tb/tb_capture_pkt_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_pkt_buffer.sv
// capture_pkt_buffer: store-and-forward packet buffer behind the capture stage.
// A packet becomes visible downstream only after its tlast word is stored.
// A packet that does not fit is dropped whole; the capture stage is never
// back-pressured.
// Optional statistics (pkt_count, drop_count, fill_words) are built only when
// CAPTURE_PKT_BUFFER_STATS_EN is defined. Otherwise these outputs are tied to 0.
module capture_pkt_buffer #(
  parameter int DEPTH_LOG2 = 9,
  parameter int WIDTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [WIDTH-1:0]      m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [15:0]           pkt_count,
  output logic [31:0]           drop_count,
  output logic [DEPTH_LOG2:0]   fill_words
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2:0] ptr_t;
  typedef enum logic [1:0] {IDLE, WRITE, DISCARD} wstate_t;

  logic [WIDTH:0] mem [0:DEPTH-1];
  logic [WIDTH:0] rd_word;

  // rd_ptr counts words actually handed downstream. fetch_ptr counts words
  // moved into the output register. Space is freed only on handoff, so the
  // word sitting in the output register still counts as occupied.
  ptr_t    wr_ptr, wr_ptr_d, commit_ptr, commit_ptr_d;
  ptr_t    rd_ptr, rd_ptr_d, fetch_ptr;
  wstate_t state, state_d;
  logic    beat, full, store, load, xfer;

  assign s_tready = rst_n;
  assign beat     = s_tvalid && s_tready;
  // Full is judged on registered pointers, so a same-cycle read cannot save a beat.
  assign full     = (wr_ptr - rd_ptr) == ptr_t'(DEPTH);
  assign xfer     = m_tvalid && m_tready;
  // Only committed words are prefetched. This keeps partial packets invisible.
  assign load     = (fetch_ptr != commit_ptr) && (!m_tvalid || m_tready);
  assign rd_ptr_d = xfer ? rd_ptr + 1'b1 : rd_ptr;
  assign rd_word  = mem[fetch_ptr[DEPTH_LOG2-1:0]];

  // Write-side next state: store, commit on tlast, or rewind and discard on overflow
  always_comb begin
    state_d      = state;
    wr_ptr_d     = wr_ptr;
    commit_ptr_d = commit_ptr;
    store        = 1'b0;
    if (beat) begin
      case (state)
        IDLE, WRITE: begin
          if (!full) begin
            store    = 1'b1;
            wr_ptr_d = wr_ptr + 1'b1;
            if (s_tlast) begin
              commit_ptr_d = wr_ptr + 1'b1;
              state_d      = IDLE;
            end else begin
              state_d = WRITE;
            end
          end else begin
            wr_ptr_d = commit_ptr;
            state_d  = s_tlast ? IDLE : DISCARD;
          end
        end
        DISCARD: if (s_tlast) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Write-side state and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_d;
      wr_ptr     <= wr_ptr_d;
      commit_ptr <= commit_ptr_d;
      rd_ptr     <= rd_ptr_d;
    end
  end

  // Packet RAM. It is not cleared on reset.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_tlast, s_tdata};
  end

  // One-word prefetch output register for first-word fall-through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_ptr <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tdata   <= '0;
    end else if (load) begin
      fetch_ptr <= fetch_ptr + 1'b1;
      m_tvalid  <= 1'b1;
      m_tlast   <= rd_word[WIDTH];
      m_tdata   <= rd_word[WIDTH-1:0];
    end else if (xfer) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end
  end

`ifdef CAPTURE_PKT_BUFFER_STATS_EN
  logic               commit, drop, last_xfer;
  logic [15:0]        pkt_cnt_q;
  logic [31:0]        drop_cnt_q;
  logic [DEPTH_LOG2:0] fill_q;

  assign commit    = store && s_tlast;
  assign drop      = beat && (state != DISCARD) && full;
  assign last_xfer = xfer && m_tlast;

  // Statistics follow the causing beat by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fill_q     <= '0;
    end else begin
      case ({commit, last_xfer})
        2'b10:   pkt_cnt_q <= pkt_cnt_q + 16'd1;
        2'b01:   pkt_cnt_q <= pkt_cnt_q - 16'd1;
        default: pkt_cnt_q <= pkt_cnt_q;
      endcase
      if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_q <= drop_cnt_q + 32'd1;
      fill_q <= wr_ptr_d - rd_ptr_d;
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign drop_count = drop_cnt_q;
  assign fill_words = fill_q;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
  assign fill_words = '0;
`endif
endmodule

// File: tb/tb_capture_pkt_buffer.sv
// Directed bench for capture_pkt_buffer (DEPTH_LOG2=6).
// Statistics expectations track CAPTURE_PKT_BUFFER_STATS_EN.
module tb_capture_pkt_buffer;
  localparam int DL = 6;
`ifdef CAPTURE_PKT_BUFFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   s_tdata = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [63:0]   m_tdata;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b0;
  logic [15:0]   pkt_count;
  logic [31:0]   drop_count;
  logic [DL:0]   fill_words;
  int checks = 0, failures = 0;

  capture_pkt_buffer #(.DEPTH_LOG2(DL), .WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .pkt_count(pkt_count), .drop_count(drop_count), .fill_words(fill_words)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // n beats with consecutive data from start; tlast on the final beat if last
  task automatic send_words(input logic [63:0] start, input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = start + 64'(i);
      s_tlast  = last && (i == n - 1);
      step();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Collect len words expected as first, first+1, ... with tlast every plen words
  task automatic recv(input logic [63:0] first, input int len, input int plen,
                      input bit toggle, output int cycles);
    int got = 0;
    int cyc = 0;
    logic [63:0] held = '0;
    bit stalled = 1'b0;
    while (got < len && cyc < 400) begin
      m_tready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== held) begin
          failures++;
          $display("FAIL stall_hold got v=%0b d=%0h want v=1 d=%0h", m_tvalid, m_tdata, held);
        end
        stalled = 1'b0;
      end
      if (m_tvalid) begin
        if (m_tready) begin
          checks++;
          if (m_tdata !== first + 64'(got) || m_tlast !== ((got % plen) == plen - 1)) begin
            failures++;
            $display("FAIL recv_word idx=%0d got d=%0h l=%0b want d=%0h l=%0b", got, m_tdata,
                     m_tlast, first + 64'(got), ((got % plen) == plen - 1));
          end
          got++;
        end else begin
          held    = m_tdata;
          stalled = 1'b1;
        end
      end
      step();
      cyc++;
    end
    m_tready = 1'b0;
    cycles = cyc;
    checks++;
    if (got != len) begin
      failures++;
      $display("FAIL recv_count got %0d want %0d", got, len);
    end
  endtask

  task automatic check_idle(input string tag, input logic [15:0] pk, input logic [31:0] dr,
                            input logic [DL:0] fl);
    checks++;
    if (m_tvalid !== 1'b0 || pkt_count !== pk || drop_count !== dr || fill_words !== fl) begin
      failures++;
      $display("FAIL %s got v=%0b pkt=%0d drop=%0h fill=%0d want v=0 pkt=%0d drop=%0h fill=%0d",
               tag, m_tvalid, pkt_count, drop_count, fill_words, pk, dr, fl);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (s_tready !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 64'd0) begin
      failures++;
      $display("FAIL reset_out got rdy=%0b l=%0b d=%0h want 0 0 0", s_tready, m_tlast, m_tdata);
    end
    check_idle("reset_state", 16'd0, 32'd0, '0);
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_tready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got %0b want 1", s_tready);
    end
    step();
  endtask

  task automatic test_single();
    int lat = 0;
    int cyc;
    send_words(64'd1, 52, 1'b1);
    while (!m_tvalid && lat < 6) begin step(); lat++; end
    checks++;
    if (lat > 2) begin
      failures++;
      $display("FAIL commit_latency got %0d want <=2", lat);
    end
    checks++;
    if (pkt_count !== (STATS ? 16'd1 : 16'd0) || fill_words !== (STATS ? 7'd52 : 7'd0)) begin
      failures++;
      $display("FAIL single_stats got pkt=%0d fill=%0d", pkt_count, fill_words);
    end
    recv(64'd1, 52, 52, 1'b0, cyc);
    step();
    check_idle("single_drained", 16'd0, 32'd0, '0);
  endtask

  task automatic test_overflow();
    int cyc;
    m_tready = 1'b0;
    send_words(64'd101, 52, 1'b1);
    send_words(64'd201, 52, 1'b1);
    checks++;
    if (pkt_count !== (STATS ? 16'd1 : 16'd0) || drop_count !== (STATS ? 32'd1 : 32'd0) ||
        fill_words !== (STATS ? 7'd52 : 7'd0)) begin
      failures++;
      $display("FAIL overflow_stats got pkt=%0d drop=%0d fill=%0d", pkt_count, drop_count, fill_words);
    end
    recv(64'd101, 52, 52, 1'b0, cyc);
    step(); step();
    check_idle("overflow_drained", 16'd0, STATS ? 32'd1 : 32'd0, '0);
  endtask

  task automatic test_backpressure();
    int cyc;
    send_words(64'd301, 52, 1'b1);
    recv(64'd301, 52, 52, 1'b1, cyc);
    step();
    check_idle("bp_drained", 16'd0, STATS ? 32'd1 : 32'd0, '0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int w = 0;
    send_words(64'd500, 20, 1'b1);
    send_words(64'd520, 20, 1'b1);
    while (!m_tvalid && w < 6) begin step(); w++; end
    recv(64'd500, 40, 20, 1'b0, cyc);
    checks++;
    if (cyc != 40) begin
      failures++;
      $display("FAIL b2b_throughput got %0d cycles want 40", cyc);
    end
    step();
    check_idle("b2b_drained", 16'd0, STATS ? 32'd1 : 32'd0, '0);
  endtask

  // Ten packets through a 64-word RAM; each write overlaps the previous readout
  task automatic test_wrap();
    int cyc;
    send_words(64'd1000, 52, 1'b1);
    for (int k = 0; k < 10; k++) begin
      fork
        recv(64'd1000 + 64'(k * 100), 52, 52, 1'b0, cyc);
        if (k < 9) send_words(64'd1000 + 64'((k + 1) * 100), 52, 1'b1);
      join
    end
    step();
    check_idle("wrap_drained", 16'd0, STATS ? 32'd1 : 32'd0, '0);
  endtask

  task automatic test_reset_mid();
    int cyc;
    send_words(64'd600, 20, 1'b0);
    rst_n = 1'b0;
    step();
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      failures++;
      $display("FAIL in_reset got v=%0b rdy=%0b want 0 0", m_tvalid, s_tready);
    end
    rst_n = 1'b1;
    step();
    check_idle("after_reset", 16'd0, 32'd0, '0);
    send_words(64'd700, 52, 1'b1);
    recv(64'd700, 52, 52, 1'b0, cyc);
    step(); step();
    check_idle("reset_mid_drained", 16'd0, 32'd0, '0);
  endtask

  task automatic test_drop_sat();
    int cyc;
`ifdef CAPTURE_PKT_BUFFER_STATS_EN
    force dut.drop_cnt_q = 32'hFFFF_FFFE;
    step();
    release dut.drop_cnt_q;
`endif
    m_tready = 1'b0;
    send_words(64'd800, 52, 1'b1);
    send_words(64'd900, 52, 1'b1);
    send_words(64'd950, 52, 1'b1);
    checks++;
    if (drop_count !== (STATS ? 32'hFFFF_FFFF : 32'd0) || pkt_count !== (STATS ? 16'd1 : 16'd0) ||
        fill_words !== (STATS ? 7'd52 : 7'd0)) begin
      failures++;
      $display("FAIL drop_sat got drop=%0h pkt=%0d fill=%0d", drop_count, pkt_count, fill_words);
    end
    recv(64'd800, 52, 52, 1'b0, cyc);
    step(); step();
    check_idle("sat_drained", 16'd0, STATS ? 32'hFFFF_FFFF : 32'd0, '0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_drop_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
